log2: RTL and testbench

LOG2 -- requirements
Module: log2

---
 rtl/log2_if.sv | 15 +
 rtl/log2.sv | 45 ++++
 tb/tb_log2.sv | 84 ++++++++
 3 files changed

// File: rtl/log2_if.sv
// log2_if: operand/result bundle; master drives in_valid/num, slave returns out_valid/degree/ceil_degree/is_pow2/zero
interface log2_if #(
  parameter int WIDTH = 8,
  parameter int DEG_W = 3
);
  logic             in_valid;
  logic [WIDTH-1:0] num;
  logic             out_valid;
  logic [DEG_W-1:0] degree;
  logic [DEG_W:0]   ceil_degree;
  logic             is_pow2;
  logic             zero;
  modport master (output in_valid, num, input out_valid, degree, ceil_degree, is_pow2, zero);
  modport slave  (input in_valid, num, output out_valid, degree, ceil_degree, is_pow2, zero);
endinterface

// File: rtl/log2.sv
// log2: registered floor/ceil log2 encoder; ports clk, rst_n (async active-low), bus (log2_if.slave: in_valid/num in, out_valid/degree/ceil_degree/is_pow2/zero out)
module log2 #(
  parameter int WIDTH = 8,
  parameter int DEG_W = 3
) (
  input  logic   clk,
  input  logic   rst_n,
  log2_if.slave  bus
);
  logic             out_valid_d, out_valid_q;
  logic [DEG_W-1:0] degree_d, degree_q, enc;
  logic [DEG_W:0]   ceil_degree_d, ceil_degree_q;
  logic             is_pow2_d, is_pow2_q, zero_d, zero_q, nz, p2;
  always_comb begin
    enc = '0;
    for (int i = 0; i < WIDTH; i++) if (bus.num[i]) enc = DEG_W'(i);
    nz = |bus.num;
    p2 = nz && ((bus.num & (bus.num - WIDTH'(1))) == '0);
    out_valid_d = bus.in_valid;
    degree_d = bus.in_valid ? enc : degree_q;
    ceil_degree_d = bus.in_valid ? ({1'b0, enc} + ((nz && !p2) ? (DEG_W+1)'(1) : '0)) : ceil_degree_q;
    is_pow2_d = bus.in_valid ? p2 : is_pow2_q;
    zero_d = bus.in_valid ? !nz : zero_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      degree_q <= '0;
      ceil_degree_q <= '0;
      is_pow2_q <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      degree_q <= degree_d;
      ceil_degree_q <= ceil_degree_d;
      is_pow2_q <= is_pow2_d;
      zero_q <= zero_d;
    end
  end
  assign bus.out_valid = out_valid_q;
  assign bus.degree = degree_q;
  assign bus.ceil_degree = ceil_degree_q;
  assign bus.is_pow2 = is_pow2_q;
  assign bus.zero = zero_q;
endmodule

// File: tb/tb_log2.sv
// tb_log2: directed and exhaustive checks of the log2 encoder
module tb_log2;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_run = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  log2_if #(.WIDTH(8), .DEG_W(3)) bus();
  log2 #(.WIDTH(8), .DEG_W(3)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic expect_res(string tag, logic ov, int d, int c, logic p, logic z);
    check({tag, ".out_valid"}, 32'(bus.out_valid), 32'(ov));
    check({tag, ".degree"}, 32'(bus.degree), d);
    check({tag, ".ceil_degree"}, 32'(bus.ceil_degree), c);
    check({tag, ".is_pow2"}, 32'(bus.is_pow2), 32'(p));
    check({tag, ".zero"}, 32'(bus.zero), 32'(z));
  endtask
  task automatic drive(logic v, logic [7:0] n);
    bus.in_valid = v;
    bus.num = n;
    @(posedge clk);
    #1;
  endtask
  typedef struct {logic [7:0] n; int d; int c;} vec_t;
  vec_t np[4] = '{'{8'd3, 1, 2}, '{8'd5, 2, 3}, '{8'd100, 6, 7}, '{8'd255, 7, 8}};
  initial begin
    int d, c;
    bus.in_valid = 1'b0;
    bus.num = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    expect_res("reset", 1'b0, 0, 0, 1'b0, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    drive(1'b0, 8'd5);
    expect_res("post_reset_idle", 1'b0, 0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 8'(1 << i));
      expect_res($sformatf("pow2_%0d", i), 1'b1, i, i, 1'b1, 1'b0);
    end
    foreach (np[k]) begin
      drive(1'b1, np[k].n);
      expect_res($sformatf("nonpow_%0d", np[k].n), 1'b1, np[k].d, np[k].c, 1'b0, 1'b0);
    end
    drive(1'b1, 8'd0);
    expect_res("zero", 1'b1, 0, 0, 1'b0, 1'b1);
    drive(1'b1, 8'd64);
    expect_res("hold_cap", 1'b1, 6, 6, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 8'd3);
      expect_res($sformatf("hold_%0d", i), 1'b0, 6, 6, 1'b1, 1'b0);
    end
    drive(1'b0, 8'bx);
    expect_res("x_idle", 1'b0, 6, 6, 1'b1, 1'b0);
    drive(1'b1, 8'd200);
    expect_res("b2b_200", 1'b1, 7, 8, 1'b0, 1'b0);
    drive(1'b1, 8'd7);
    #2 rst_n = 1'b0;
    #1;
    expect_res("async_rst", 1'b0, 0, 0, 1'b0, 1'b0);
    bus.in_valid = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    drive(1'b0, 8'd9);
    expect_res("rel_idle0", 1'b0, 0, 0, 1'b0, 1'b0);
    drive(1'b0, 8'd9);
    expect_res("rel_idle1", 1'b0, 0, 0, 1'b0, 1'b0);
    for (int v = 0; v < 256; v++) begin
      d = 0;
      for (int k = 0; k < 8; k++) if ((1 << k) <= v) d = k;
      c = 0;
      while ((1 << c) < v) c++;
      drive(1'b1, 8'(v));
      expect_res($sformatf("exh_%0d", v), 1'b1, d, c, (v != 0) && ($countones(v) == 1), v == 0);
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
